// File: rtl/edge_pair_checker.sv
// Compares the posedge- and negedge-captured copies of one data bus and tracks
// link health with a lock/fault FSM plus saturating sample/mismatch counters.
//   state     | meaning
//   S_IDLE    | no counted compare since reset/clear
//   S_ACQUIRE | counting consecutive matches toward lock
//   S_LOCKED  | link stable; counting consecutive mismatches toward fault
//   S_FAULT   | sticky fault, left only through clear or rst
module edge_pair_checker #(
  parameter int               WIDTH       = 8,
  parameter int               CNT_W       = 16,
  parameter int               LOCK_COUNT  = 4,
  parameter int               FAULT_COUNT = 3,
  parameter logic [WIDTH-1:0] RST_POS     = '0,
  parameter logic [WIDTH-1:0] RST_NEG     = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] pos_in,
  input  logic [WIDTH-1:0] neg_in,
  output logic             cmp_valid,
  output logic             match,
  output logic [WIDTH-1:0] last_diff,
  output logic             locked,
  output logic             fault,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] mismatch_cnt
);

  localparam int MRUN_W = (LOCK_COUNT < 2)  ? 1 : $clog2(LOCK_COUNT + 1);
  localparam int FRUN_W = (FAULT_COUNT < 2) ? 1 : $clog2(FAULT_COUNT + 1);
  localparam logic [MRUN_W-1:0] LOCK_TGT  = MRUN_W'(LOCK_COUNT);
  localparam logic [FRUN_W-1:0] FAULT_TGT = FRUN_W'(FAULT_COUNT);

  typedef enum logic [1:0] {S_IDLE, S_ACQUIRE, S_LOCKED, S_FAULT} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   p_q, p_d, n_q, n_d;
  logic               v_q, v_d;
  logic [MRUN_W-1:0]  mrun_q, mrun_d;
  logic [FRUN_W-1:0]  frun_q, frun_d;
  logic               cmp_valid_q, cmp_valid_d;
  logic               match_q, match_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic [CNT_W-1:0]   scnt_q, scnt_d, mcnt_q, mcnt_d;

  logic counted;
  logic is_match;

  // The upstream reset pattern is not real data and must leave no trace.
  assign counted  = v_q && !((p_q == RST_POS) && (n_q == RST_NEG));
  assign is_match = (p_q == n_q);

  always_comb begin
    p_d         = p_q;
    n_d         = n_q;
    v_d         = 1'b0;
    state_d     = state_q;
    mrun_d      = mrun_q;
    frun_d      = frun_q;
    cmp_valid_d = 1'b0;
    match_d     = match_q;
    diff_d      = diff_q;
    scnt_d      = scnt_q;
    mcnt_d      = mcnt_q;

    if (en) begin
      p_d = pos_in;
      n_d = neg_in;
      v_d = 1'b1;
    end

    if (counted) begin
      cmp_valid_d = 1'b1;
      match_d     = is_match;
      diff_d      = p_q ^ n_q;
      if (scnt_q != '1) scnt_d = scnt_q + CNT_W'(1);
      if (!is_match && (mcnt_q != '1)) mcnt_d = mcnt_q + CNT_W'(1);

      case (state_q)
        S_IDLE: begin
          state_d = S_ACQUIRE;
          mrun_d  = is_match ? MRUN_W'(1) : '0;
          if (is_match && (LOCK_COUNT == 1)) begin
            state_d = S_LOCKED;
            frun_d  = '0;
          end
        end
        S_ACQUIRE: begin
          if (is_match) begin
            mrun_d = mrun_q + MRUN_W'(1);
            if (mrun_d >= LOCK_TGT) begin
              state_d = S_LOCKED;
              frun_d  = '0;
            end
          end else begin
            mrun_d = '0;
          end
        end
        S_LOCKED: begin
          if (is_match) begin
            frun_d = '0;
          end else begin
            frun_d = frun_q + FRUN_W'(1);
            if (frun_d >= FAULT_TGT) state_d = S_FAULT;
          end
        end
        default: state_d = S_FAULT;
      endcase
    end

    // Clear also drops the captured pair and anything about to be compared.
    if (clear) begin
      v_d         = 1'b0;
      state_d     = S_IDLE;
      mrun_d      = '0;
      frun_d      = '0;
      cmp_valid_d = 1'b0;
      match_d     = 1'b0;
      diff_d      = '0;
      scnt_d      = '0;
      mcnt_d      = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q         <= '0;
      n_q         <= '0;
      v_q         <= 1'b0;
      state_q     <= S_IDLE;
      mrun_q      <= '0;
      frun_q      <= '0;
      cmp_valid_q <= 1'b0;
      match_q     <= 1'b0;
      diff_q      <= '0;
      scnt_q      <= '0;
      mcnt_q      <= '0;
    end else begin
      p_q         <= p_d;
      n_q         <= n_d;
      v_q         <= v_d;
      state_q     <= state_d;
      mrun_q      <= mrun_d;
      frun_q      <= frun_d;
      cmp_valid_q <= cmp_valid_d;
      match_q     <= match_d;
      diff_q      <= diff_d;
      scnt_q      <= scnt_d;
      mcnt_q      <= mcnt_d;
    end
  end

  assign cmp_valid    = cmp_valid_q;
  assign match        = match_q;
  assign last_diff    = diff_q;
  assign locked       = (state_q == S_LOCKED);
  assign fault        = (state_q == S_FAULT);
  assign sample_cnt   = scnt_q;
  assign mismatch_cnt = mcnt_q;

endmodule

// File: tb/tb_edge_pair_checker.sv
// Directed bench for edge_pair_checker: lock, interrupted acquire, fault,
// clear, reset-pattern skip, async reset and counter saturation (CNT_W=4 copy).
module tb_edge_pair_checker;

  logic        clk = 1'b0;
  logic        rst, en, clear;
  logic [7:0]  pos_in, neg_in;

  logic        cmp_valid, match, locked, fault;
  logic [7:0]  last_diff;
  logic [15:0] sample_cnt, mismatch_cnt;

  logic        s_cmp_valid, s_match, s_locked, s_fault;
  logic [7:0]  s_last_diff;
  logic [3:0]  s_sample_cnt, s_mismatch_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  edge_pair_checker dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear),
    .pos_in(pos_in), .neg_in(neg_in),
    .cmp_valid(cmp_valid), .match(match), .last_diff(last_diff),
    .locked(locked), .fault(fault),
    .sample_cnt(sample_cnt), .mismatch_cnt(mismatch_cnt)
  );

  edge_pair_checker #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .en(en), .clear(clear),
    .pos_in(pos_in), .neg_in(neg_in),
    .cmp_valid(s_cmp_valid), .match(s_match), .last_diff(s_last_diff),
    .locked(s_locked), .fault(s_fault),
    .sample_cnt(s_sample_cnt), .mismatch_cnt(s_mismatch_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; clear = 1'b0; pos_in = 8'h00; neg_in = 8'h00;
    tick();
    n_cmp++;
    if ({cmp_valid, match, last_diff, locked, fault, sample_cnt, mismatch_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got cv=%0b m=%0b d=%0h l=%0b f=%0b s=%0d mm=%0d, want all 0",
               cmp_valid, match, last_diff, locked, fault, sample_cnt, mismatch_cnt);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (sample_cnt !== 16'd0 || cmp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: got s=%0d cv=%0b, want 0 0", sample_cnt, cmp_valid);
    end
  endtask

  task automatic test_lock();
    pos_in = 8'h5A; neg_in = 8'h5A;
    for (int i = 0; i <= 5; i++) begin
      en = (i <= 3);
      tick();
      n_cmp++;
      if (cmp_valid !== (i >= 1 && i <= 4)) begin
        n_err++;
        $display("FAIL lock_cmp_valid[%0d]: got %0b", i, cmp_valid);
      end
      n_cmp++;
      if (locked !== (i >= 4) || sample_cnt !== 16'((i > 4) ? 4 : i) || mismatch_cnt !== 16'd0) begin
        n_err++;
        $display("FAIL lock_state[%0d]: got l=%0b s=%0d mm=%0d, want l=%0b s=%0d mm=0",
                 i, locked, sample_cnt, mismatch_cnt, (i >= 4), (i > 4) ? 4 : i);
      end
      if (i >= 1 && i <= 4) begin
        n_cmp++;
        if (match !== 1'b1 || last_diff !== 8'h00) begin
          n_err++;
          $display("FAIL lock_match[%0d]: got m=%0b d=%0h, want 1 00", i, match, last_diff);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    n_cmp++;
    if (locked !== 1'b1) begin
      n_err++;
      $display("FAIL async_pre_locked: got %0b want 1", locked);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if ({cmp_valid, match, last_diff, locked, fault, sample_cnt, mismatch_cnt} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got l=%0b s=%0d m=%0b, want all 0", locked, sample_cnt, match);
    end
    #1 rst = 1'b0;
    tick();
    n_cmp++;
    if (locked !== 1'b0 || sample_cnt !== 16'd0 || cmp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL async_after: got l=%0b s=%0d cv=%0b, want 0 0 0", locked, sample_cnt, cmp_valid);
    end
  endtask

  task automatic test_acquire_interrupted();
    logic [7:0] np[8];
    np = '{8'h5A, 8'h5A, 8'h5A, 8'h5B, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
    pos_in = 8'h5A;
    for (int i = 0; i <= 8; i++) begin
      en = (i < 8);
      if (i < 8) neg_in = np[i];
      tick();
      if (i >= 1) begin
        n_cmp++;
        if (cmp_valid !== 1'b1 || sample_cnt !== 16'(i) || locked !== (i == 8)) begin
          n_err++;
          $display("FAIL acq_progress[%0d]: got cv=%0b s=%0d l=%0b, want 1 %0d %0b",
                   i, cmp_valid, sample_cnt, locked, i, (i == 8));
        end
      end
      if (i == 4) begin
        n_cmp++;
        if (last_diff !== 8'h01 || mismatch_cnt !== 16'd1 || match !== 1'b0) begin
          n_err++;
          $display("FAIL acq_mismatch: got d=%0h mm=%0d m=%0b, want 01 1 0", last_diff, mismatch_cnt, match);
        end
      end
    end
  endtask

  task automatic test_fault();
    logic       mm[8];
    logic [7:0] exp_mm[8];
    logic       exp_f[8];
    mm     = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_mm = '{8'd2, 8'd3, 8'd3, 8'd4, 8'd5, 8'd6, 8'd6, 8'd6};
    exp_f  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    pos_in = 8'h11;
    for (int i = 0; i <= 8; i++) begin
      en = (i < 8);
      if (i < 8) neg_in = mm[i] ? 8'h22 : 8'h11;
      tick();
      if (i >= 1) begin
        n_cmp++;
        if (fault !== exp_f[i-1] || locked !== !exp_f[i-1] ||
            mismatch_cnt !== 16'(exp_mm[i-1]) || sample_cnt !== 16'(8 + i) ||
            match !== !mm[i-1] || last_diff !== (mm[i-1] ? 8'h33 : 8'h00)) begin
          n_err++;
          $display("FAIL fault_seq[%0d]: got f=%0b l=%0b mm=%0d s=%0d m=%0b d=%0h, want f=%0b l=%0b mm=%0d s=%0d",
                   i - 1, fault, locked, mismatch_cnt, sample_cnt, match, last_diff,
                   exp_f[i-1], !exp_f[i-1], exp_mm[i-1], 8 + i);
        end
      end
    end
    en = 1'b1; neg_in = 8'h22;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0; en = 1'b0;
    n_cmp++;
    if ({cmp_valid, match, last_diff, locked, fault, sample_cnt, mismatch_cnt} !== '0) begin
      n_err++;
      $display("FAIL clear_now: got cv=%0b f=%0b s=%0d mm=%0d d=%0h, want all 0",
               cmp_valid, fault, sample_cnt, mismatch_cnt, last_diff);
    end
    tick();
    n_cmp++;
    if (cmp_valid !== 1'b0 || sample_cnt !== 16'd0 || fault !== 1'b0) begin
      n_err++;
      $display("FAIL clear_drop: got cv=%0b s=%0d f=%0b, want 0 0 0", cmp_valid, sample_cnt, fault);
    end
  endtask

  task automatic test_reset_pattern();
    en = 1'b1; pos_in = 8'h3C; neg_in = 8'h3C;
    tick();
    neg_in = 8'h3D;
    tick();
    pos_in = 8'h00; neg_in = 8'hFF;
    for (int i = 0; i < 7; i++) begin
      if (i == 5) en = 1'b0;
      tick();
      if (i >= 1) begin
        n_cmp++;
        if (cmp_valid !== 1'b0 || sample_cnt !== 16'd2 || mismatch_cnt !== 16'd1 ||
            match !== 1'b0 || last_diff !== 8'h01 || locked !== 1'b0 || fault !== 1'b0) begin
          n_err++;
          $display("FAIL rst_pattern[%0d]: got cv=%0b s=%0d mm=%0d m=%0b d=%0h, want 0 2 1 0 01",
                   i, cmp_valid, sample_cnt, mismatch_cnt, match, last_diff);
        end
      end
    end
  endtask

  task automatic test_saturation();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    en = 1'b1; pos_in = 8'h01; neg_in = 8'h02;
    for (int i = 0; i <= 20; i++) begin
      en = (i < 20);
      tick();
      if (i == 15) begin
        n_cmp++;
        if (s_sample_cnt !== 4'd15 || s_mismatch_cnt !== 4'd15) begin
          n_err++;
          $display("FAIL sat_reach: got s=%0d mm=%0d, want 15 15", s_sample_cnt, s_mismatch_cnt);
        end
      end
    end
    n_cmp++;
    if (s_sample_cnt !== 4'd15 || s_mismatch_cnt !== 4'd15) begin
      n_err++;
      $display("FAIL sat_hold: got s=%0d mm=%0d, want 15 15", s_sample_cnt, s_mismatch_cnt);
    end
    n_cmp++;
    if (sample_cnt !== 16'd20 || mismatch_cnt !== 16'd20 || last_diff !== 8'h03) begin
      n_err++;
      $display("FAIL sat_wide: got s=%0d mm=%0d d=%0h, want 20 20 03", sample_cnt, mismatch_cnt, last_diff);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_async_reset();
    test_acquire_interrupted();
    test_fault();
    test_reset_pattern();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
